// File: rtl/decode_ctrl_stage_if.sv
// decode_ctrl_stage_if: fetch-to-execute decode bus; master drives i_valid/i_instr/i_flush/i_out_ready, slave returns o_in_ready/o_valid and decoded controls with o_rd/o_rs1
interface decode_ctrl_stage_if;
  logic i_valid, o_in_ready, i_flush, o_valid, i_out_ready;
  logic [31:0] i_instr;
  logic o_reg_write, o_mem_read, o_mem_write, o_d_unsigned, o_csr_write, o_word_op, o_custom, o_illegal;
  logic [1:0] o_d_size, o_mem_to_reg;
  logic [4:0] o_rd, o_rs1;
  modport master (
    output i_valid, i_instr, i_flush, i_out_ready,
    input o_in_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_d_size, o_d_unsigned,
          o_mem_to_reg, o_csr_write, o_word_op, o_custom, o_illegal, o_rd, o_rs1
  );
  modport slave (
    input i_valid, i_instr, i_flush, i_out_ready,
    output o_in_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_d_size, o_d_unsigned,
           o_mem_to_reg, o_csr_write, o_word_op, o_custom, o_illegal, o_rd, o_rs1
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered main-control decode with two-entry skid buffer; ports i_clk, i_rst_n (async active-low) and bus (decode_ctrl_stage_if.slave)
module decode_ctrl_stage #(
  parameter int XLEN = 32,
  parameter logic [3:0] CUSTOM_EN = 4'b0000
) (
  input logic i_clk,
  input logic i_rst_n,
  decode_ctrl_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic reg_write, mem_read, mem_write;
    logic [1:0] d_size;
    logic d_unsigned;
    logic [1:0] mem_to_reg;
    logic csr_write, word_op, custom, illegal;
    logic [4:0] rd, rs1;
  } ctrl_t;
  localparam bit RV64 = XLEN == 64;
  state_t state, state_nxt;
  ctrl_t dec, m, s;
  logic in_ready, accept, ld_m, ld_s, bad, unused_hi;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd, rs1;
  assign op = bus.i_instr[6:0];
  assign rd = bus.i_instr[11:7];
  assign f3 = bus.i_instr[14:12];
  assign rs1 = bus.i_instr[19:15];
  assign unused_hi = ^bus.i_instr[31:20];
  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (op)
      7'b0110011, 7'b0010011, 7'b0010111: dec.reg_write = 1'b1;
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.mem_to_reg = 2'b11;
      end
      7'b1101111, 7'b1100111: begin
        dec.reg_write = 1'b1;
        dec.mem_to_reg = 2'b10;
      end
      7'b0000011: begin
        dec.reg_write = 1'b1;
        dec.mem_read = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.d_size = f3[1:0];
        dec.d_unsigned = f3[2];
        bad = f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.d_size = f3[1:0];
        bad = f3[2] || (!RV64 && f3 == 3'b011);
      end
      7'b1110011: begin
        dec.csr_write = f3[1:0] == 2'b01 ? 1'b1 : |rs1;
        dec.reg_write = f3[1:0] == 2'b01 ? |rd : 1'b1;
        bad = f3[1:0] == 2'b00;
      end
      7'b0111011, 7'b0011011: begin
        dec.reg_write = 1'b1;
        dec.word_op = 1'b1;
        bad = !RV64;
      end
      7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011: begin
        dec.reg_write = 1'b1;
        dec.custom = 1'b1;
        bad = !CUSTOM_EN[op[6:5]];
      end
      default: bad = 1'b1;
    endcase
    if (bad) dec = '0;
    dec.illegal = bad;
    dec.rd = rd;
    dec.rs1 = rs1;
  end
  assign accept = bus.i_valid && in_ready && !bus.i_flush;
  always_comb begin
    state_nxt = state;
    ld_m = 1'b0;
    ld_s = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt = accept ? ONE : EMPTY;
        ld_m = accept;
      end
      ONE: begin
        state_nxt = accept ? (bus.i_out_ready ? ONE : TWO) : (bus.i_out_ready ? EMPTY : ONE);
        ld_m = accept && bus.i_out_ready;
        ld_s = accept && !bus.i_out_ready;
      end
      TWO: begin
        state_nxt = bus.i_out_ready ? ONE : TWO;
        ld_m = bus.i_out_ready;
      end
      default: state_nxt = EMPTY;
    endcase
    if (bus.i_flush) state_nxt = EMPTY;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      m <= '0;
      s <= '0;
    end else begin
      state <= state_nxt;
      in_ready <= state_nxt != TWO;
      if (ld_m) m <= state == TWO ? s : dec;
      if (ld_s) s <= dec;
    end
  assign bus.o_valid = state != EMPTY;
  assign bus.o_in_ready = in_ready;
  assign bus.o_reg_write = m.reg_write;
  assign bus.o_mem_read = m.mem_read;
  assign bus.o_mem_write = m.mem_write;
  assign bus.o_d_size = m.d_size;
  assign bus.o_d_unsigned = m.d_unsigned;
  assign bus.o_mem_to_reg = m.mem_to_reg;
  assign bus.o_csr_write = m.csr_write;
  assign bus.o_word_op = m.word_op;
  assign bus.o_custom = m.custom;
  assign bus.o_illegal = m.illegal;
  assign bus.o_rd = m.rd;
  assign bus.o_rs1 = m.rs1;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: queue-model checker for XLEN=32/CUSTOM_EN=0000 and XLEN=64/CUSTOM_EN=0001 instances plus directed literal checks
module tb_decode_ctrl_stage;
  typedef struct packed {
    logic rw, mr, mw;
    logic [1:0] sz;
    logic un;
    logic [1:0] m2r;
    logic cw, wo, cu, il;
    logic [4:0] rd, rs1;
  } ctl_t;
  localparam logic [31:0] LW = 32'h0002A283, LD = 32'h00003283, CSRR = 32'h300022F3;
  localparam logic [31:0] CSRW = 32'h30009073, CUS0 = 32'h0000000B;
  logic clk = 1'b0;
  logic rst_n, valid, flush, out_ready, rdy32, rdy64;
  logic [31:0] instr;
  int n_cmp = 0, n_bad = 0;
  ctl_t q32[$], q64[$];
  ctl_t a32, a64, e;
  logic [4:0] fired[$];
  decode_ctrl_stage_if b32(), b64();
  assign b32.i_valid = valid;
  assign b32.i_instr = instr;
  assign b32.i_flush = flush;
  assign b32.i_out_ready = out_ready;
  assign b64.i_valid = valid;
  assign b64.i_instr = instr;
  assign b64.i_flush = flush;
  assign b64.i_out_ready = out_ready;
  assign a32 = {b32.o_reg_write, b32.o_mem_read, b32.o_mem_write, b32.o_d_size, b32.o_d_unsigned,
                b32.o_mem_to_reg, b32.o_csr_write, b32.o_word_op, b32.o_custom, b32.o_illegal, b32.o_rd, b32.o_rs1};
  assign a64 = {b64.o_reg_write, b64.o_mem_read, b64.o_mem_write, b64.o_d_size, b64.o_d_unsigned,
                b64.o_mem_to_reg, b64.o_csr_write, b64.o_word_op, b64.o_custom, b64.o_illegal, b64.o_rd, b64.o_rs1};
  decode_ctrl_stage #(.XLEN(32), .CUSTOM_EN(4'b0000)) u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32.slave));
  decode_ctrl_stage #(.XLEN(64), .CUSTOM_EN(4'b0001)) u64 (.i_clk(clk), .i_rst_n(rst_n), .bus(b64.slave));
  always #5 clk = ~clk;
  function automatic ctl_t dec(input logic [31:0] ins, input bit rv64, input logic [3:0] cen);
    ctl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    bit ok;
    int k;
    c = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    ok = 1'b1;
    k = op == 7'h0B ? 0 : op == 7'h2B ? 1 : op == 7'h5B ? 2 : op == 7'h7B ? 3 : -1;
    if (op == 7'h33 || op == 7'h13 || op == 7'h17) c.rw = 1'b1;
    else if (op == 7'h37) begin c.rw = 1'b1; c.m2r = 2'd3; end
    else if (op == 7'h6F || op == 7'h67) begin c.rw = 1'b1; c.m2r = 2'd2; end
    else if (op == 7'h03) begin
      c.rw = 1'b1; c.mr = 1'b1; c.m2r = 2'd1;
      case (f3)
        3'd0: c.sz = 2'd0;
        3'd1: c.sz = 2'd1;
        3'd2: c.sz = 2'd2;
        3'd4: begin c.sz = 2'd0; c.un = 1'b1; end
        3'd5: begin c.sz = 2'd1; c.un = 1'b1; end
        3'd3: if (rv64) c.sz = 2'd3; else ok = 1'b0;
        3'd6: if (rv64) begin c.sz = 2'd2; c.un = 1'b1; end else ok = 1'b0;
        default: ok = 1'b0;
      endcase
    end
    else if (op == 7'h23) begin
      c.mw = 1'b1;
      if (f3 < 3'd3) c.sz = f3[1:0];
      else if (f3 == 3'd3 && rv64) c.sz = 2'd3;
      else ok = 1'b0;
    end
    else if (op == 7'h73) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin c.cw = 1'b1; c.rw = ins[11:7] != 5'd0; end
      else if (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin c.rw = 1'b1; c.cw = ins[19:15] != 5'd0; end
      else ok = 1'b0;
    end
    else if (op == 7'h3B || op == 7'h1B) begin
      if (rv64) begin c.rw = 1'b1; c.wo = 1'b1; end else ok = 1'b0;
    end
    else if (k >= 0) begin
      ok = cen[k[1:0]];
      c.rw = 1'b1;
      c.cu = 1'b1;
    end
    else ok = 1'b0;
    if (!ok) c = '0;
    c.il = !ok;
    c.rd = ins[11:7];
    c.rs1 = ins[19:15];
    return c;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    valid = v;
    instr = ins;
    flush = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q32.delete();
      q64.delete();
      rdy32 <= 1'b1;
      rdy64 <= 1'b1;
    end else if (flush) begin
      q32.delete();
      q64.delete();
      rdy32 <= 1'b1;
      rdy64 <= 1'b1;
    end else begin
      if (q32.size() != 0 && out_ready) void'(q32.pop_front());
      if (valid && rdy32) q32.push_back(dec(instr, 1'b0, 4'b0000));
      rdy32 <= q32.size() < 2;
      if (q64.size() != 0 && out_ready) void'(q64.pop_front());
      if (valid && rdy64) q64.push_back(dec(instr, 1'b1, 4'b0001));
      rdy64 <= q64.size() < 2;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("valid32", 32'(b32.o_valid), 32'(q32.size() != 0));
      chk("in_ready32", 32'(b32.o_in_ready), 32'(rdy32));
      if (q32.size() != 0) chk("ctl32", 32'(a32), 32'(q32[0]));
      chk("valid64", 32'(b64.o_valid), 32'(q64.size() != 0));
      chk("in_ready64", 32'(b64.o_in_ready), 32'(rdy64));
      if (q64.size() != 0) chk("ctl64", 32'(a64), 32'(q64[0]));
    end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] tbl [17] = '{32'h00503023, 32'h0010009B, 32'h00004283, 32'h00006283, 32'h000000EF,
                              32'h000052B7, 32'h0000000F, 32'h00000001, 32'h00000073, 32'h00007283,
                              32'h00004023, 32'h0000007B, 32'h00000297, 32'h300062F3, 32'h3000D073,
                              32'h005282BB, 32'h00001283};
    logic [31:0] bp [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    int idx;
    bit acc;
    e = dec(LD, 1'b1, 4'b0000);
    chk("model_ld64_size", 32'(e.sz), 32'd3);
    e = dec(LD, 1'b0, 4'b0000);
    chk("model_ld32_illegal", 32'(e.il), 32'd1);
    e = dec(CSRW, 1'b0, 4'b0000);
    chk("model_csrw", 32'({e.cw, e.rw}), 32'b10);
    rst_n = 1'b1;
    valid = 1'b1;
    instr = LW;
    flush = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid32", 32'(b32.o_valid), 32'd0);
    chk("rst_in_ready32", 32'(b32.o_in_ready), 32'd1);
    chk("rst_ctl32", 32'(a32), 32'd0);
    chk("rst_ctl64", 32'(a64), 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, LW, 1'b0, 1'b1);
    chk("lw_valid", 32'(b32.o_valid), 32'd1);
    chk("lw_ctl", 32'({a32.rw, a32.mr, a32.sz, a32.un, a32.m2r, a32.rd}), 32'b1_1_10_0_01_00101);
    cyc(1'b1, LD, 1'b0, 1'b1);
    chk("ld64", 32'({a64.sz, a64.un, a64.il}), 32'b11_0_0);
    chk("ld32", 32'({a32.il, a32.rw, a32.mr}), 32'b1_0_0);
    cyc(1'b1, CSRR, 1'b0, 1'b1);
    chk("csrr", 32'({a32.rw, a32.cw}), 32'b10);
    cyc(1'b1, CSRW, 1'b0, 1'b1);
    chk("csrw", 32'({a32.cw, a32.rw}), 32'b10);
    cyc(1'b1, CUS0, 1'b0, 1'b1);
    chk("custom0_en", 32'({a64.cu, a64.il}), 32'b10);
    chk("custom0_dis", 32'({a32.cu, a32.il}), 32'b01);
    foreach (tbl[i]) cyc(1'b1, tbl[i], 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || b32.o_valid); c++) begin
      valid = idx < 4;
      instr = bp[idx < 4 ? idx : 0];
      out_ready = c >= 3;
      if (b32.o_valid && out_ready) fired.push_back(b32.o_rd);
      acc = valid && b32.o_in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (c == 0) chk("bp_ready_c0", 32'(b32.o_in_ready), 32'd1);
      if (c == 1) chk("bp_ready_c1", 32'(b32.o_in_ready), 32'd0);
      if (c == 2) chk("bp_hold", 32'({b32.o_in_ready, b32.o_valid, b32.o_rd}), 32'b0_1_00001);
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_fired", 32'(fired.size()), 32'd4);
    foreach (fired[i]) chk("bp_order", 32'(fired[i]), 32'(i + 1));
    cyc(1'b1, 32'h00500293, 1'b0, 1'b0);
    cyc(1'b1, 32'h00600313, 1'b0, 1'b0);
    chk("two_ready", 32'(b32.o_in_ready), 32'd0);
    cyc(1'b1, 32'h01F00F93, 1'b1, 1'b0);
    chk("flush_two", 32'({b32.o_valid, b32.o_in_ready}), 32'b01);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("flush_empty", 32'(b32.o_valid), 32'd0);
    cyc(1'b1, 32'h00500293, 1'b0, 1'b0);
    cyc(1'b1, 32'h01F00F93, 1'b1, 1'b1);
    chk("flush_one", 32'({b32.o_valid, b32.o_in_ready}), 32'b01);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("flush_drop", 32'(b64.o_valid), 32'd0);
    cyc(1'b1, LW, 1'b0, 1'b0);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'({b32.o_valid, b64.o_valid, b32.o_in_ready}), 32'b001);
    chk("midrst_ctl", 32'(a64), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, LW, 1'b0, 1'b1);
    chk("post_rst", 32'({b64.o_valid, b64.o_rd}), 32'b1_00101);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, parametrised successor to the core's combinational main control decode. Takes a fetched 32-bit instruction over a valid/ready handshake, generates register-file, DMEM, CSR and write-back-source controls, and holds them in a two-entry skid buffer feeding execute. Adds RV64 load/store and word-op decode, configurable custom-opcode enables, illegal-instruction flagging, flush, and full-throughput backpressure.

## Interface

Parameters:
- XLEN, default 32: datapath width. Legal values are 32 and 64; 64 enables LD/LWU/SD/OP-32/OP-IMM-32.
- CUSTOM_EN, default 4'b0000: bit k enables the custom-k opcode (0001011, 0101011, 1011011, 1111011).

Ports:

Clock, reset and handshake:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_valid, input, 1: upstream instruction valid.
- o_in_ready, output, 1: stage can accept an instruction.
- i_instr, input, 32: instruction word.
- i_flush, input, 1: discard all held and incoming instructions.
- o_valid, output, 1: output entry valid.
- i_out_ready, input, 1: downstream accepts the output entry.

Decoded controls:
- o_reg_write, output, 1: register-file write enable.
- o_mem_read, output, 1: DMEM read.
- o_mem_write, output, 1: DMEM write.
- o_d_size, output, 2: access size (00 B, 01 H, 10 W, 11 D).
- o_d_unsigned, output, 1: zero-extend load.
- o_mem_to_reg, output, 2: write-back source (00 ALU, 01 DMEM, 10 PC+4, 11 IMM).
- o_csr_write, output, 1: CSR write enable.
- o_word_op, output, 1: RV64 32-bit op (OP-32 / OP-IMM-32).
- o_custom, output, 1: custom-opcode instruction.
- o_illegal, output, 1: undecodable instruction.
- o_rd, output, 5: instr[11:7].
- o_rs1, output, 5: instr[19:15].

## Operation

- Decode is combinational on i_instr. The result is captured on acceptance (i_valid && o_in_ready && !i_flush).
- Opcode decode:
  - R, I, AUIPC: reg_write, ALU source.
  - LUI: reg_write, IMM source.
  - JAL, JALR: reg_write, PC+4 source.
  - LOAD: reg_write, mem_read, DMEM source.
  - STORE: mem_write only.
- LOAD funct3 mapping:
  - 000/001/010: size 00/01/10, signed.
  - 100/101: size 00/01, unsigned.
  - XLEN=64 only: 011 gives size 11; 110 gives size 10, unsigned.
  - Any other funct3 is illegal.
- STORE funct3: 000/001/010 give size 00/01/10. 011 gives size 11 when XLEN=64. Any other funct3 is illegal.
- SYSTEM (CSR ops):
  - CSRRW/CSRRWI: csr_write=1; reg_write=(rd!=0).
  - CSRRS/CSRRC/CSRRSI/CSRRCI: reg_write=1; csr_write=(rs1 field!=0).
  - funct3 000 and 100 are illegal.
- XLEN=64 only: OP-32 (0111011) and OP-IMM-32 (0011011) decode as reg_write, ALU source, word_op=1. With XLEN=32 they are illegal.
- Custom-k with CUSTOM_EN[k]=1: reg_write, ALU source, custom=1. With CUSTOM_EN[k]=0: illegal.
- Illegal conditions: instr[1:0]!=2'b11, unknown opcode, or bad funct3 as listed. When illegal:
  - o_illegal=1.
  - reg_write, mem_read, mem_write, csr_write, word_op, custom are all 0.
  - d_size=00, d_unsigned=0, mem_to_reg=00.
  - rd and rs1 are still passed through.
- Buffer FSM (main register M drives the outputs; skid register S):
  - EMPTY: accept → ONE.
  - ONE: accept with i_out_ready → ONE (M replaced). Accept without i_out_ready → TWO (new entry into S). i_out_ready without accept → EMPTY.
  - TWO: i_out_ready → ONE (S moves to M). Accept does not occur in TWO.
- o_in_ready = (state != TWO), registered.
- o_valid = (state != EMPTY).
- Order is preserved: no entry is dropped or duplicated.
- i_flush has priority over all handshake activity: the next state is EMPTY, and an input presented in the flush cycle is discarded.

## Timing

- Reset (asynchronous assert, synchronous release): state EMPTY, o_valid=0, o_in_ready=1. All control outputs, o_rd and o_rs1 are 0.
- Latency: one cycle from acceptance in EMPTY to o_valid=1 with the decoded controls.
- Throughput: one instruction per cycle while i_out_ready=1.
- Outputs stay stable while o_valid=1 and i_out_ready=0.
- o_in_ready falls the cycle after the second entry is captured. It rises the cycle after TWO drains.
- Flush: o_valid=0 and o_in_ready=1 on the following cycle.
- Reset mid-stream discards all entries immediately.

## Test plan

- Reset: hold i_rst_n=0 with i_valid=1 and i_instr=0x0002A283 → o_valid=0, o_in_ready=1, all controls 0. After release, the first acceptance gives o_valid=1 one cycle later.
- lw x5,0(x5) (0x0002A283), XLEN=32 → reg_write=1, mem_read=1, d_size=10, d_unsigned=0, mem_to_reg=01, rd=5.
- ld x5,0(x0) (0x00003283):
  - XLEN=64 → d_size=11, d_unsigned=0, illegal=0.
  - XLEN=32 → illegal=1, reg_write=0, mem_read=0.
- CSR decode:
  - csrr x5,mstatus (0x300022F3) → reg_write=1, csr_write=0.
  - csrw mstatus,x1 (0x30009073, CSRRW with rd=0) → csr_write=1, reg_write=0.
- Backpressure: four back-to-back valid instructions with i_out_ready=0 for 3 cycles → two accepted, o_in_ready=0 from cycle 2. After i_out_ready=1, all four emerge in order with no loss or duplicate.
- Flush in TWO with a concurrent i_valid → next cycle o_valid=0, o_in_ready=1. The concurrent instruction never appears. Custom-0 (0x0000000B) gives custom=1 with CUSTOM_EN=4'b0001 and illegal=1 with 4'b0000.
